imem_ctrl: RTL
==============

IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter AW, default 9, meaning SRAM word-address width (512 words).
REQ-002 SHALL have port clk  input  1  single clock for all state; also drives both SRAM port clocks.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports if_req  input  1; if_addr  input  32; if_gnt  output  1: fetch request, byte address, accept.
REQ-005 SHALL have ports if_rvalid  output  1; if_rdata  output  32; if_rready  input  1: fetch response handshake.
REQ-006 SHALL have ports ld_req  input  1; ld_addr  input  32; ld_wdata  input  32; ld_wmask  input  4; ld_gnt  output  1: loader write path.
REQ-007 SHALL have ports ld_done  input  1 (boot-complete pulse); ld_reload  input  1 (re-enter boot pulse); run  output  1; ld_cnt  output  10 (words written).
REQ-008 SHALL have ports sram_csb0, sram_web0  output  1; sram_wmask0  output  4; sram_addr0  output  AW; sram_din0  output  32: SRAM port 0, write-only use.
REQ-009 SHALL have ports sram_csb1  output  1; sram_addr1  output  AW; sram_dout1  input  32: SRAM port 1, read-only use.

Function
REQ-010 SHALL implement states BOOT (after reset) and RUN; run=1 only in RUN.
REQ-011 SHALL move BOOT->RUN on ld_done=1 and RUN->BOOT on ld_reload=1; ld_reload wins if both are high.
REQ-012 SHALL keep if_gnt=0 in BOOT; fetch requests wait, none are dropped.
REQ-013 SHALL drive word address = addr[AW+1:2] on both ports; addr[1:0] ignored.
REQ-014 SHALL grant a loader write combinationally: ld_gnt = ld_req, in both states.
REQ-015 SHALL drive sram_csb0=0, sram_web0=0, sram_wmask0=ld_wmask and sram_din0=ld_wdata in the ld_gnt cycle; otherwise csb0=1, web0=1, wmask0=0.
REQ-016 SHALL increment ld_cnt on each ld_gnt, saturate at 1023, and clear it on the BOOT entry caused by ld_reload.
REQ-017 SHALL compute if_gnt = if_req & run & ~hold_vld & ~(pend & ~if_rready) & ~conflict.
REQ-018 SHALL define conflict = ld_req & (ld_addr word == if_addr word); same-cycle read/write collision blocks the fetch and the write proceeds.
REQ-019 SHALL drive sram_csb1=0 and sram_addr1=if_addr word only in an if_gnt cycle; otherwise csb1=1.
REQ-020 SHALL set pend on the clock edge ending an if_gnt cycle; read data is taken from sram_dout1 in the next cycle (latency 1).
REQ-021 SHALL, when pend=1 and hold_vld=0, drive if_rvalid=1 and if_rdata=sram_dout1.
REQ-022 SHALL, when pend=1 and if_rready=0, capture sram_dout1 into the hold register and set hold_vld.
REQ-023 SHALL, when hold_vld=1, drive if_rvalid=1 and if_rdata=hold; hold_vld clears on if_rready.
REQ-024 SHALL clear pend when its data is consumed or captured, unless a new if_gnt occurs in the same cycle; back-to-back fetches give one word per cycle while if_rready=1.
REQ-025 SHALL flush pend and hold_vld on ld_reload, drive if_rvalid=0 from the next cycle, and drop the in-flight response.
REQ-026 SHALL drive if_rdata=0 whenever if_rvalid=0.

Reset
REQ-027 SHALL, while rst_n=0, force state=BOOT, pend=0, hold_vld=0, hold=0 and ld_cnt=0.
REQ-028 SHALL, while rst_n=0, force outputs if_gnt=0, if_rvalid=0, if_rdata=0, run=0, csb0=1, web0=1, wmask0=0 and csb1=1.
REQ-029 SHALL accept no operation in the first cycle after rst_n deasserts.
REQ-030 SHALL discard any operation in flight when reset asserts, with no partial response after release.

Verification
REQ-031 SHALL cover: reset, write 0x13 to words 0..3, pulse ld_done -> ld_cnt=4, run=1; fetch 0x0 -> if_gnt, then if_rvalid next cycle with 0x00000013.
REQ-032 SHALL cover: four back-to-back fetches 0x0..0xC with if_rready=1 -> four consecutive if_rvalid cycles, data in order.
REQ-033 SHALL cover: fetch 0x4 then if_rready=0 for 3 cycles -> rdata held stable, if_gnt=0 throughout, released on ready.
REQ-034 SHALL cover: ld_req to word 5 and if_req to 0x14 in the same cycle -> write done, if_gnt=0; fetch granted next cycle and returns the new data.
REQ-035 SHALL cover: if_req in BOOT -> if_gnt=0; ld_reload during a pending fetch -> no if_rvalid, run=0, ld_cnt=0.
REQ-036 SHALL cover: rst_n low mid-fetch -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/imem_ctrl.sv
// Instruction-memory controller: boot-time loader writes into SRAM port 0,
// run-time instruction fetch reads from SRAM port 1 with a one-entry hold
// register to absorb fetch-response backpressure.
//
//   state | meaning
//   BOOT  | loader owns the SRAM, fetches are held off (if_gnt=0)
//   RUN   | fetches are granted, loader writes still accepted
module imem_ctrl #(
  parameter int AW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          if_rready,
  input  logic          ld_req,
  input  logic [31:0]   ld_addr,
  input  logic [31:0]   ld_wdata,
  input  logic [3:0]    ld_wmask,
  output logic          ld_gnt,
  input  logic          ld_done,
  input  logic          ld_reload,
  output logic          run,
  output logic [9:0]    ld_cnt,
  output logic          sram_csb0,
  output logic          sram_web0,
  output logic [3:0]    sram_wmask0,
  output logic [AW-1:0] sram_addr0,
  output logic [31:0]   sram_din0,
  output logic          sram_csb1,
  output logic [AW-1:0] sram_addr1,
  input  logic [31:0]   sram_dout1
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t        state;
  logic          rdy;
  logic          pend;
  logic          hold_vld;
  logic [31:0]   hold;
  logic [AW-1:0] if_word;
  logic [AW-1:0] ld_word;
  logic          conflict;
  logic          unused_addr_bits;

  assign if_word = if_addr[AW+1:2];
  assign ld_word = ld_addr[AW+1:2];

  // Byte-offset and out-of-range address bits carry no meaning here.
  assign unused_addr_bits = ^{if_addr[31:AW+2], if_addr[1:0],
                              ld_addr[31:AW+2], ld_addr[1:0]};

  // Blocks all grants during the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy <= 1'b0;
    else        rdy <= 1'b1;
  end

  // Loader write path: granted immediately, straight onto SRAM port 0.
  always_comb begin
    ld_gnt      = ld_req & rdy;
    sram_csb0   = ~ld_gnt;
    sram_web0   = ~ld_gnt;
    sram_wmask0 = ld_gnt ? ld_wmask : 4'b0000;
    sram_addr0  = ld_word;
    sram_din0   = ld_wdata;
  end

  // Fetch grant: a same-word write in the same cycle wins over the read.
  always_comb begin
    conflict   = ld_req & (ld_word == if_word);
    if_gnt     = if_req & run & ~hold_vld & ~(pend & ~if_rready) & ~conflict;
    sram_csb1  = ~if_gnt;
    sram_addr1 = if_word;
  end

  // Response mux: hold register has priority over live SRAM data.
  always_comb begin
    if_rvalid = hold_vld | pend;
    if (hold_vld)  if_rdata = hold;
    else if (pend) if_rdata = sram_dout1;
    else           if_rdata = 32'h0;
  end

  // Boot/run sequencing with the saturating loader write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= BOOT;
      run    <= 1'b0;
      ld_cnt <= 10'd0;
    end else begin
      case (state)
        BOOT: begin
          if (ld_gnt && ld_cnt != 10'd1023) ld_cnt <= ld_cnt + 10'd1;
          if (!ld_reload && ld_done) begin
            state <= RUN;
            run   <= 1'b1;
          end
        end
        RUN: begin
          if (ld_reload) begin
            state  <= BOOT;
            run    <= 1'b0;
            ld_cnt <= 10'd0;
          end else if (ld_gnt && ld_cnt != 10'd1023) begin
            ld_cnt <= ld_cnt + 10'd1;
          end
        end
        default: begin
          state <= BOOT;
          run   <= 1'b0;
        end
      endcase
    end
  end

  // Read pipeline: every pending word is either consumed or parked in hold,
  // so pend simply follows the grant; reload drops anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      hold_vld <= 1'b0;
      hold     <= 32'h0;
    end else if (ld_reload) begin
      pend     <= 1'b0;
      hold_vld <= 1'b0;
    end else begin
      pend <= if_gnt;
      if (pend && !if_rready) begin
        hold     <= sram_dout1;
        hold_vld <= 1'b1;
      end else if (hold_vld && if_rready) begin
        hold_vld <= 1'b0;
      end
    end
  end

endmodule
